pipe_trace_buffer: RTL and testbench

Synthesizable retire-trace recorder for the pipelined MIPS-Lite core. It replaces per-cycle console printing with an on-chip circular buffer. Each cycle it decodes the ID-stage opcode/funct into an instruction class and records {cycle stamp, PC, class, writeback data}. A programmable trigger then freezes a pre/post window, and the frozen trace is read back through a synchronous port.

---
 rtl/pipe_trace_buffer.sv | 189 ++++++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
// Retire-trace recorder: decodes ID-stage opcode/funct into a class and records
// {stamp, PC, class, WB data} in a circular buffer frozen by a pre/post trigger window.
module pipe_trace_buffer #(
   parameter int PC_W      = 32,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int TS_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cap_valid,
   input  logic [PC_W-1:0]            cap_pc,
   input  logic [5:0]                 cap_opcode,
   input  logic [5:0]                 cap_funct,
   input  logic [DATA_W-1:0]          cap_wd,
   input  logic                       arm,
   input  logic [1:0]                 trig_mode,
   input  logic [PC_W-1:0]            trig_pc,
   input  logic [4:0]                 trig_class,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic                       rd_valid,
   output logic                       rd_err,
   output logic [TS_W-1:0]            rd_ts,
   output logic [PC_W-1:0]            rd_pc,
   output logic [4:0]                 rd_class,
   output logic [DATA_W-1:0]          rd_wd,
   output logic [$clog2(DEPTH):0]     count,
   output logic [1:0]                 state,
   output logic                       triggered
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
   localparam logic [AW-1:0] PCNT_ONE  = AW'(1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

   state_t            st;
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     pcnt;
   logic [TS_W-1:0]   ts;

   logic [TS_W-1:0]   mem_ts  [DEPTH];
   logic [PC_W-1:0]   mem_pc  [DEPTH];
   logic [4:0]        mem_cls [DEPTH];
   logic [DATA_W-1:0] mem_wd  [DEPTH];

   logic [4:0]        cls_p0;
   logic              wr_p0;
   logic              hit_p0;
   logic [AW-1:0]     rd_addr_p0;
   logic              rd_miss_p0;

   function automatic logic [4:0] decode_class(input logic [5:0] op, input logic [5:0] fn);
      logic [4:0] c;
      c = 5'd0;
      if (op == 6'd0) begin
         case (fn)
            6'd32:   c = 5'd1;
            6'd34:   c = 5'd2;
            6'd36:   c = 5'd3;
            6'd37:   c = 5'd4;
            6'd42:   c = 5'd5;
            6'd0:    c = 5'd6;
            6'd8:    c = 5'd7;
            6'd27:   c = 5'd8;
            6'd16:   c = 5'd9;
            6'd18:   c = 5'd10;
            default: c = 5'd0;
         endcase
      end else begin
         case (op)
            6'd35:   c = 5'd11;
            6'd43:   c = 5'd12;
            6'd4:    c = 5'd13;
            6'd30:   c = 5'd14;
            6'd2:    c = 5'd15;
            6'd12:   c = 5'd16;
            default: c = 5'd0;
         endcase
      end
      return c;
   endfunction

   // capture stage p0: decode, write enable, trigger match
   always_comb begin
      cls_p0 = decode_class(cap_opcode, cap_funct);
      wr_p0  = !arm && cap_valid && (st == S_ARMED || st == S_POST);
      hit_p0 = 1'b0;
      case (trig_mode)
         2'd0:    hit_p0 = 1'b1;
         2'd1:    hit_p0 = (cap_pc == trig_pc);
         2'd2:    hit_p0 = (cls_p0 == trig_class);
         default: hit_p0 = 1'b0;
      endcase
      rd_addr_p0 = ((count == FULL_CNT) ? wptr : '0) + rd_idx;
      rd_miss_p0 = (st != S_DONE) || ({1'b0, rd_idx} >= count);
   end

   always_ff @(posedge clk) begin
      if (wr_p0) begin
         mem_ts[wptr]  <= ts;
         mem_pc[wptr]  <= cap_pc;
         mem_cls[wptr] <= cls_p0;
         mem_wd[wptr]  <= cap_wd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= S_IDLE;
         count     <= '0;
         wptr      <= '0;
         pcnt      <= '0;
         ts        <= '0;
         triggered <= 1'b0;
      end else begin
         ts <= ts + 1'b1;
         if (arm) begin
            st        <= S_ARMED;
            count     <= '0;
            wptr      <= '0;
            pcnt      <= '0;
            triggered <= 1'b0;
         end else begin
            if (wr_p0) begin
               wptr <= wptr + 1'b1;
               if (count != FULL_CNT)
                  count <= count + 1'b1;
            end
            case (st)
               S_ARMED: begin
                  if (cap_valid && hit_p0) begin
                     triggered <= 1'b1;
                     if (POST_TRIG == 0) begin
                        st <= S_DONE;
                     end else begin
                        st   <= S_POST;
                        pcnt <= POST_INIT;
                     end
                  end
               end
               S_POST: begin
                  if (cap_valid) begin
                     pcnt <= pcnt - 1'b1;
                     if (pcnt == PCNT_ONE)
                        st <= S_DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // read stage p1: one-cycle registered readback, data held between requests
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_ts    <= '0;
         rd_pc    <= '0;
         rd_class <= '0;
         rd_wd    <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_err <= rd_miss_p0;
            if (rd_miss_p0) begin
               rd_ts    <= '0;
               rd_pc    <= '0;
               rd_class <= '0;
               rd_wd    <= '0;
            end else begin
               rd_ts    <= mem_ts[rd_addr_p0];
               rd_pc    <= mem_pc[rd_addr_p0];
               rd_class <= mem_cls[rd_addr_p0];
               rd_wd    <= mem_wd[rd_addr_p0];
            end
         end
      end
   end

   assign state = st;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Randomized bench for pipe_trace_buffer against a queue-based model of the trace window.
module tb_pipe_trace_buffer;

   localparam int DEPTH = 16;
   localparam int POST_TRIG = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cap_valid = 1'b0;
   logic [31:0] cap_pc = '0;
   logic [5:0]  cap_opcode = '0;
   logic [5:0]  cap_funct = '0;
   logic [31:0] cap_wd = '0;
   logic        arm = 1'b0;
   logic [1:0]  trig_mode = '0;
   logic [31:0] trig_pc = '0;
   logic [4:0]  trig_class = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_idx = '0;
   logic        rd_valid, rd_err, triggered;
   logic [15:0] rd_ts;
   logic [31:0] rd_pc, rd_wd;
   logic [4:0]  rd_class;
   logic [4:0]  count;
   logic [1:0]  state;

   pipe_trace_buffer #(.PC_W(32), .DATA_W(32), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(16)) dut (
      .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_opcode(cap_opcode),
      .cap_funct(cap_funct), .cap_wd(cap_wd), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
      .trig_class(trig_class), .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_err(rd_err),
      .rd_ts(rd_ts), .rd_pc(rd_pc), .rd_class(rd_class), .rd_wd(rd_wd), .count(count), .state(state),
      .triggered(triggered));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ts;
      logic [31:0] pc;
      logic [4:0]  cls;
      logic [31:0] wd;
   } ent_t;

   ent_t        q[$];
   int          m_state;
   int          m_post;
   bit          m_trig;
   logic [15:0] m_ts;
   int          n_checks = 0;
   int          n_pass = 0;

   int functs[10] = '{32, 34, 36, 37, 42, 0, 8, 27, 16, 18};
   int ops[6]     = '{35, 43, 4, 30, 2, 12};

   function automatic logic [4:0] m_class(input logic [5:0] op, input logic [5:0] fn);
      if (op == 0) begin
         for (int i = 0; i < 10; i++) if (fn == functs[i]) return 5'(i + 1);
      end else begin
         for (int i = 0; i < 6; i++) if (op == ops[i]) return 5'(i + 11);
      end
      return 5'd0;
   endfunction

   function automatic logic [85:0] exp_rd(input int idx);
      if (m_state != 3 || idx >= q.size()) return {1'b1, 85'd0};
      return {1'b0, q[idx].ts, q[idx].pc, q[idx].cls, q[idx].wd};
   endfunction

   task automatic model_reset();
      q.delete(); m_state = 0; m_post = 0; m_trig = 0; m_ts = '0;
   endtask

   task automatic model_clock();
      ent_t e;
      bit   hit;
      if (arm) begin
         q.delete(); m_state = 1; m_trig = 0;
      end else if ((m_state == 1 || m_state == 2) && cap_valid) begin
         e.ts = m_ts; e.pc = cap_pc; e.cls = m_class(cap_opcode, cap_funct); e.wd = cap_wd;
         q.push_back(e);
         if (q.size() > DEPTH) void'(q.pop_front());
         if (m_state == 1) begin
            hit = (trig_mode == 0) || (trig_mode == 1 && cap_pc == trig_pc) ||
                  (trig_mode == 2 && e.cls == trig_class);
            if (hit) begin
               m_trig = 1;
               if (POST_TRIG == 0) m_state = 3;
               else begin m_state = 2; m_post = POST_TRIG; end
            end
         end else begin
            m_post--;
            if (m_post == 0) m_state = 3;
         end
      end
      m_ts = m_ts + 16'd1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic cap(input logic [31:0] pc, input logic [5:0] op, input logic [5:0] fn, input bit v);
      cap_valid = v; cap_pc = pc; cap_opcode = op; cap_funct = fn; cap_wd = $urandom;
      tick();
      cap_valid = 1'b0;
   endtask

   task automatic do_arm(input logic [1:0] mode);
      trig_mode = mode; arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_read(input int idx);
      rd_en = 1'b1; rd_idx = 4'(idx);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++;
      if ({state, count, triggered, rd_valid, rd_err, rd_pc, rd_ts, rd_class, rd_wd} !== '0)
         $display("FAIL reset_state: state=%0d count=%0d trig=%0b rd_valid=%0b rd_err=%0b rd_pc=%h want all zero",
                  state, count, triggered, rd_valid, rd_err, rd_pc);
      else n_pass++;
   endtask

   task automatic test_mode0();
      logic [85:0] e;
      do_arm(2'd0);
      n_checks++;
      if (state !== 2'd1 || count !== 5'd0) $display("FAIL m0_armed: state=%0d count=%0d want 1/0", state, count);
      else n_pass++;
      for (int i = 0; i < 3; i++) cap(32'(i * 4), 6'($urandom), 6'($urandom), 1'b1);
      n_checks++;
      if (state !== 2'd2 || triggered !== 1'b1 || count !== 5'd3)
         $display("FAIL m0_post: state=%0d trig=%0b count=%0d want 2/1/3", state, triggered, count);
      else n_pass++;
      for (int i = 3; i < 5; i++) cap(32'(i * 4), 6'($urandom), 6'($urandom), 1'b1);
      n_checks++;
      if (state !== 2'd3 || count !== 5'd5 || count !== 5'(q.size()))
         $display("FAIL m0_done: state=%0d count=%0d want 3/5", state, count);
      else n_pass++;
      e = exp_rd(0); do_read(0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'h0 || {rd_err, rd_ts, rd_pc, rd_class, rd_wd} !== e)
         $display("FAIL m0_rd0: valid=%0b pc=%h ts=%0d wd=%h want pc 0 ts %0d wd %h", rd_valid, rd_pc, rd_ts, rd_wd, e[84:69], e[31:0]);
      else n_pass++;
      e = exp_rd(4); do_read(4);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'h10 || {rd_err, rd_ts, rd_pc, rd_class, rd_wd} !== e)
         $display("FAIL m0_rd4: valid=%0b pc=%h want pc 10", rd_valid, rd_pc);
      else n_pass++;
   endtask

   task automatic test_mode1();
      logic [85:0] e;
      int          bad;
      trig_pc = 32'h40;
      do_arm(2'd1);
      for (int i = 0; i < 30; i++) cap(32'(i * 4), 6'($urandom), 6'($urandom), 1'b1);
      n_checks++;
      if (state !== 2'd3 || count !== 5'd16) $display("FAIL m1_done: state=%0d count=%0d want 3/16", state, count);
      else n_pass++;
      do_read(0);
      n_checks++;
      if (rd_pc !== 32'h14) $display("FAIL m1_rd0: pc=%h want 14", rd_pc); else n_pass++;
      do_read(11);
      n_checks++;
      if (rd_pc !== 32'h40) $display("FAIL m1_rd11: pc=%h want 40", rd_pc); else n_pass++;
      do_read(15);
      n_checks++;
      if (rd_pc !== 32'h50) $display("FAIL m1_rd15: pc=%h want 50", rd_pc); else n_pass++;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         e = exp_rd(i); do_read(i);
         if (rd_valid !== 1'b1 || {rd_err, rd_ts, rd_pc, rd_class, rd_wd} !== e) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL m1_all_entries: %0d entries differ, want 0", bad); else n_pass++;
   endtask

   task automatic test_mode2();
      logic [5:0]  op;
      logic [15:0] ts9;
      trig_class = 5'd14;
      do_arm(2'd2);
      for (int i = 1; i <= 12; i++) begin
         op = 6'($urandom);
         if (op == 6'd30) op = 6'd0;
         if (i == 8) op = 6'd30;
         cap(32'h100 + 32'(i * 4), op, 6'($urandom), 1'b1);
         if (i == 9) begin
            cap(32'hdead, 6'd30, 6'd0, 1'b0);
            cap(32'hbeef, 6'd30, 6'd0, 1'b0);
         end
      end
      n_checks++;
      if (state !== 2'd3 || count !== 5'd12) $display("FAIL m2_done: state=%0d count=%0d want 3/12", state, count);
      else n_pass++;
      do_read(7);
      n_checks++;
      if (rd_class !== 5'd14 || rd_pc !== 32'h120) $display("FAIL m2_trig_class: class=%0d pc=%h want 14/120", rd_class, rd_pc);
      else n_pass++;
      do_read(8);
      ts9 = rd_ts;
      do_read(9);
      n_checks++;
      if (16'(rd_ts - ts9) !== 16'd3 || rd_pc !== 32'h128)
         $display("FAIL m2_bubble_gap: gap=%0d pc=%h want 3/128", 16'(rd_ts - ts9), rd_pc);
      else n_pass++;
   endtask

   task automatic test_decode();
      logic [5:0] sw_op[17] = '{0,0,0,0,0,0,0,0,0,0,35,43,4,30,2,12,63};
      logic [5:0] sw_fn[17] = '{32,34,36,37,42,0,8,27,16,18,0,0,0,0,0,0,0};
      int bad;
      trig_mode = 2'd3;
      do_arm(2'd3);
      for (int i = 0; i < 20; i++) cap(32'($urandom), 6'($urandom), 6'($urandom), 1'b1);
      n_checks++;
      if (state !== 2'd1 || count !== 5'd16 || triggered !== 1'b0)
         $display("FAIL m3_freerun: state=%0d count=%0d trig=%0b want 1/16/0", state, count, triggered);
      else n_pass++;
      bad = 0;
      for (int b = 0; b < 17; b += 5) begin
         do_arm(2'd0);
         for (int k = 0; k < 5; k++) begin
            if (b + k < 17) cap(32'(b + k), sw_op[b+k], (sw_op[b+k] == 0) ? sw_fn[b+k] : 6'($urandom), 1'b1);
            else cap(32'h0, 6'd63, 6'd0, 1'b1);
         end
         for (int k = 0; k < 5 && b + k < 17; k++) begin
            do_read(k);
            if (rd_class !== ((b + k == 16) ? 5'd0 : 5'(b + k + 1))) begin
               bad++;
               $display("FAIL decode_%0d: class=%0d want %0d", b + k, rd_class, (b + k == 16) ? 0 : b + k + 1);
            end
         end
      end
      n_checks++;
      if (bad != 0) $display("FAIL decode_sweep: %0d wrong classes, want 0", bad); else n_pass++;
   endtask

   task automatic test_rd_err();
      do_arm(2'd3);
      for (int i = 0; i < 3; i++) cap(32'(i), 6'($urandom), 6'($urandom), 1'b1);
      do_read(0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_err !== 1'b1 || {rd_ts, rd_pc, rd_class, rd_wd} !== '0)
         $display("FAIL rd_err_armed: valid=%0b err=%0b pc=%h want 1/1/0", rd_valid, rd_err, rd_pc);
      else n_pass++;
      do_arm(2'd0);
      for (int i = 0; i < 5; i++) cap(32'(i), 6'($urandom), 6'($urandom), 1'b1);
      do_read(4);
      n_checks++;
      if (rd_err !== 1'b0 || rd_pc !== 32'd4) $display("FAIL rd_last_ok: err=%0b pc=%h want 0/4", rd_err, rd_pc);
      else n_pass++;
      do_read(5);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_err !== 1'b1 || {rd_ts, rd_pc, rd_class, rd_wd} !== '0)
         $display("FAIL rd_err_idx_eq_count: valid=%0b err=%0b pc=%h want 1/1/0", rd_valid, rd_err, rd_pc);
      else n_pass++;
      tick();
      n_checks++;
      if (rd_valid !== 1'b0) $display("FAIL rd_valid_idle: valid=%0b want 0", rd_valid); else n_pass++;
   endtask

   task automatic test_abort();
      do_arm(2'd0);
      cap(32'h0, 6'd0, 6'd32, 1'b1);
      cap(32'h4, 6'd0, 6'd32, 1'b1);
      arm = 1'b1;
      cap(32'h8, 6'd0, 6'd32, 1'b1);
      arm = 1'b0;
      n_checks++;
      if (state !== 2'd1 || count !== 5'd0 || triggered !== 1'b0 || m_state != 1)
         $display("FAIL abort_arm: state=%0d count=%0d trig=%0b want 1/0/0", state, count, triggered);
      else n_pass++;
      cap(32'h0, 6'd0, 6'd32, 1'b1);
      cap(32'h4, 6'd0, 6'd32, 1'b1);
      n_checks++;
      if (state !== 2'd2 || count !== 5'd2) $display("FAIL rearm_post: state=%0d count=%0d want 2/2", state, count);
      else n_pass++;
      #3 rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (state !== 2'd0 || count !== 5'd0 || triggered !== 1'b0)
         $display("FAIL async_reset: state=%0d count=%0d trig=%0b want 0/0/0", state, count, triggered);
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) cap(32'(i), 6'($urandom), 6'($urandom), 1'b1);
      n_checks++;
      if (state !== 2'd0 || count !== 5'd0 || count !== 5'(q.size()))
         $display("FAIL idle_no_write: state=%0d count=%0d want 0/0", state, count);
      else n_pass++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_mode0();
      test_mode1();
      test_mode2();
      test_decode();
      test_rd_err();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
